// File: rtl/softplus.sv
// Softplus approximation ln(1+e^x) in signed Q8.8: a 17-knot piecewise-linear
// table over [-8, 8), zero below and identity at or above. One-cycle latency.
module softplus #(
    parameter int WIDTH = 16
) (
    input  logic             clock,
    input  logic             rst,
    input  logic [WIDTH-1:0] operand,
    output logic [WIDTH-1:0] out
);

    logic [WIDTH-1:0] out_reg;
    logic [WIDTH-1:0] result_next;
    logic [3:0]       seg;
    logic [7:0]       frac;
    logic [WIDTH-1:0] y_lo;
    logic [WIDTH-1:0] y_hi;
    logic [8:0]       delta;
    logic [16:0]      prod;
    logic [16:0]      rounded;
    logic             below;
    logic             above;

    function automatic logic [WIDTH-1:0] knot(input logic [4:0] idx);
        logic [WIDTH-1:0] y;
        case (idx)
            5'd0:    y = 16'h0000;
            5'd1:    y = 16'h0000;
            5'd2:    y = 16'h0001;
            5'd3:    y = 16'h0002;
            5'd4:    y = 16'h0005;
            5'd5:    y = 16'h000C;
            5'd6:    y = 16'h0020;
            5'd7:    y = 16'h0050;
            5'd8:    y = 16'h00B1;
            5'd9:    y = 16'h0150;
            5'd10:   y = 16'h0220;
            5'd11:   y = 16'h030C;
            5'd12:   y = 16'h0405;
            5'd13:   y = 16'h0502;
            5'd14:   y = 16'h0601;
            5'd15:   y = 16'h0700;
            default: y = 16'h0800;
        endcase
        return y;
    endfunction

    always_comb begin
        below       = $signed(operand) < -16'sd2048;
        above       = $signed(operand) >= 16'sd2048;
        // Inside [-8, 8) the integer part k fits in 4 bits; k+8 is k with its sign bit flipped.
        seg         = operand[11:8] ^ 4'b1000;
        frac        = operand[7:0];
        y_lo        = knot({1'b0, seg});
        y_hi        = knot({1'b0, seg} + 5'd1);
        delta       = 9'(y_hi - y_lo);
        prod        = {8'b0, delta} * {9'b0, frac};
        rounded     = (prod + 17'd128) >> 8;
        result_next = y_lo + rounded[WIDTH-1:0];
        if (below) begin
            result_next = '0;
        end else if (above) begin
            result_next = operand;
        end
    end

    always_ff @(posedge clock or negedge rst) begin
        if (!rst) begin
            out_reg <= '0;
        end else begin
            out_reg <= result_next;
        end
    end

    assign out = out_reg;

endmodule

// File: tb/tb_softplus.sv
// Self-checking bench for softplus: directed knot/extreme cases, exhaustive sweep,
// random streaming and asynchronous reset behaviour against an integer model.
module tb_softplus;

    logic        clock;
    logic        rst;
    logic [15:0] operand;
    logic [15:0] out;

    int total = 0;
    int bad   = 0;

    softplus #(.WIDTH(16)) dut (
        .clock   (clock),
        .rst     (rst),
        .operand (operand),
        .out     (out)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Reference: plain integer math on the real value of x in 1/256 units.
    function automatic logic [15:0] model(input logic [15:0] op);
        int knots[17] = '{0, 0, 1, 2, 5, 12, 32, 80, 177, 336, 544, 780, 1029, 1282, 1537, 1792, 2048};
        int x, k, f, ylo, yhi, r;
        x = int'($signed(op));
        if (x < -2048) return 16'h0000;
        if (x >= 2048) return op;
        k = x >>> 8;
        f = x - k * 256;
        ylo = knots[k + 8];
        yhi = knots[k + 9];
        r = ylo + ((yhi - ylo) * f + 128) / 256;
        return 16'(r);
    endfunction

    // Drive one operand just after a rising edge; the result is visible after the next one.
    task automatic apply_and_check(input logic [15:0] op, input logic [15:0] exp, input string name);
        operand = op;
        @(posedge clock);
        #1;
        total++;
        if (out !== exp) begin
            bad++;
            $display("FAIL %s: operand=%h out=%h expected=%h", name, op, out, exp);
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        operand = 16'h0400;
        repeat (3) @(posedge clock);
        #1;
        total++;
        if (out !== 16'h0000) begin
            bad++;
            $display("FAIL reset_state: out=%h expected=0000", out);
        end
        rst = 1'b1;
        apply_and_check(16'h0400, 16'h0405, "first_after_reset");
        $display("test_reset: out=%h", out);
    endtask

    task automatic test_knots();
        logic [15:0] ops[4]  = '{16'h0000, 16'hFF00, 16'h0400, 16'h0800};
        logic [15:0] exps[4] = '{16'h00B1, 16'h0050, 16'h0405, 16'h0800};
        for (int i = 0; i < 4; i++) begin
            apply_and_check(ops[i], exps[i], "knot");
            $display("knot: operand=%h out=%h", ops[i], out);
        end
        for (int k = -8; k <= 8; k++) begin
            logic [15:0] op;
            op = 16'(k * 256);
            apply_and_check(op, model(op), "knot_model");
        end
    endtask

    task automatic test_rounding();
        apply_and_check(16'h0080, 16'h0101, "rounding_half");
        $display("rounding: operand=0080 out=%h", out);
    endtask

    task automatic test_extremes();
        logic [15:0] ops[4]  = '{16'h8000, 16'hF7FF, 16'hF800, 16'h7FFF};
        logic [15:0] exps[4] = '{16'h0000, 16'h0000, 16'h0000, 16'h7FFF};
        for (int i = 0; i < 4; i++) begin
            apply_and_check(ops[i], exps[i], "extreme");
            $display("extreme: operand=%h out=%h", ops[i], out);
        end
    endtask

    task automatic test_sweep();
        int prev;
        int start_bad;
        start_bad = bad;
        prev = -1;
        for (int i = 0; i < 65536; i++) begin
            logic [15:0] op;
            op = 16'(i + 32768);
            apply_and_check(op, model(op), "sweep");
            total++;
            if (int'($signed(out)) < prev || $signed(out) < 0) begin
                bad++;
                $display("FAIL monotonic: operand=%h out=%h previous=%h required non-decreasing, non-negative",
                         op, out, 16'(prev));
            end
            prev = int'($signed(out));
        end
        $display("sweep: 65536 operands, new errors=%0d", bad - start_bad);
    endtask

    task automatic test_random();
        for (int i = 0; i < 300; i++) begin
            logic [15:0] op;
            op = (i % 2 == 0) ? 16'($urandom) : 16'($urandom_range(0, 4095) - 2048);
            apply_and_check(op, model(op), "random");
            $display("random: operand=%h out=%h", op, out);
        end
    endtask

    task automatic test_midstream_reset();
        apply_and_check(16'h0000, 16'h00B1, "pre_reset");
        operand = 16'h0400;
        #2;
        rst = 1'b0;
        #1;
        total++;
        if (out !== 16'h0000) begin
            bad++;
            $display("FAIL async_reset: out=%h expected=0000", out);
        end
        repeat (2) @(posedge clock);
        #1;
        total++;
        if (out !== 16'h0000) begin
            bad++;
            $display("FAIL reset_hold: out=%h expected=0000", out);
        end
        #1;
        rst = 1'b1;
        @(posedge clock);
        #1;
        total++;
        if (out !== 16'h0405) begin
            bad++;
            $display("FAIL reset_release: out=%h expected=0405", out);
        end
        $display("midstream_reset: out after release=%h", out);
    endtask

    task automatic test_back_to_back();
        logic [15:0] ops[6] = '{16'h0080, 16'hF800, 16'h07FF, 16'h0800, 16'hFFFF, 16'h0001};
        for (int i = 0; i < 6; i++) begin
            apply_and_check(ops[i], model(ops[i]), "back_to_back");
            $display("back_to_back: operand=%h out=%h", ops[i], out);
        end
    endtask

    initial begin
        rst = 1'b0;
        operand = 16'h0000;
        #2;
        test_reset();
        test_knots();
        test_rounding();
        test_extremes();
        test_back_to_back();
        test_random();
        test_midstream_reset();
        test_sweep();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
